// File: rtl/fifo_ssd_display_pkg.sv
// Shared constants, types and helpers for the FIFO seven-segment display stage.
package fifo_disp_pkg;

  // Active-low segment patterns, bit order DP,G,F,E,D,C,B,A (DP off in all of them)
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_LO_O  = 8'hA3;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Coherent copy of the FIFO-side inputs, refreshed once per scan frame
  typedef struct packed {
    logic [7:0] rd_data;
    logic [3:0] wr_index;
    logic [3:0] rd_index;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       mode;
  } snap_t;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fifo_ssd_display_scan_timer.sv
// Digit scan timer: slot counter, digit selector (3 -> 0, left to right),
// blanking window at the start of each slot and the frame-start strobe.
module ssd_scan_timer #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       CLK100,
  input  logic       reset,
  output logic [1:0] digit_sel_o,
  output logic       blank_o,
  output logic       frame_start_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [1:0]       digit_sel_q, digit_sel_d;
  logic             tick;

  assign tick          = (r_cnt_q == CNT_W'(REFRESH_DIV - 1));
  // The tick leaving digit 0 is the one that reloads digit 3, i.e. a new frame
  assign frame_start_o = tick && (digit_sel_q == 2'd0);
  assign blank_o       = (r_cnt_q < CNT_W'(BLANK_CYCLES));
  assign digit_sel_o   = digit_sel_q;

  // Next-state: wrap the slot counter on tick and step to the next digit
  always_comb begin
    r_cnt_d     = r_cnt_q + 1'b1;
    digit_sel_d = digit_sel_q;
    if (tick) begin
      r_cnt_d     = '0;
      digit_sel_d = digit_sel_q - 2'd1;  // 0 wraps to 3
    end
  end

  // Timer state registers
  always_ff @(posedge CLK100 or posedge reset) begin
    if (reset) begin
      r_cnt_q     <= '0;
      digit_sel_q <= 2'd3;
    end else begin
      r_cnt_q     <= r_cnt_d;
      digit_sel_q <= digit_sel_d;
    end
  end

endmodule

// File: rtl/fifo_ssd_display.sv
// FIFO status/data display: snapshots the FIFO-side inputs once per frame and
// drives a 4-digit multiplexed, active-low seven-segment display. Decimal
// points blink while the snapshot shows overflow. No handshake with the FIFO;
// all inputs are already synchronous to CLK100.
module fifo_ssd_display
  import fifo_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       CLK100,
  input  logic       reset,
  input  logic [7:0] fifo_rd_data,
  input  logic [3:0] wr_index,
  input  logic [3:0] rd_index,
  input  logic       empty,
  input  logic       full,
  input  logic       overflow,
  input  logic       mode,
  output logic [3:0] ss_anode,
  output logic [7:0] ss_cathode
);

  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [1:0]    digit_sel;
  logic          blank;
  logic          frame_start;

  snap_t         snap_q, snap_d;
  logic [FC_W-1:0] frame_cnt_q;
  logic          blink_q;
  logic [3:0]    anode_q, anode_d;
  logic [7:0]    cathode_q, cathode_d;

  ssd_scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .CLK100       (CLK100),
    .reset        (reset),
    .digit_sel_o  (digit_sel),
    .blank_o      (blank),
    .frame_start_o(frame_start)
  );

  assign snap_d = '{rd_data:  fifo_rd_data,
                    wr_index: wr_index,
                    rd_index: rd_index,
                    empty:    empty,
                    full:     full,
                    overflow: overflow,
                    mode:     mode};

  // Frame-start bookkeeping: latch the snapshot and advance the blink divider
  always_ff @(posedge CLK100 or posedge reset) begin
    if (reset) begin
      snap_q      <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (frame_start) begin
      snap_q <= snap_d;
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  // Content mux: selected digit's pattern from the snapshot, plus anode select
  always_comb begin
    cathode_d = SEG_BLANK;
    if (!snap_q.mode) begin
      case (digit_sel)
        2'd3:    cathode_d = hex_to_seg(snap_q.wr_index);
        2'd2:    cathode_d = hex_to_seg(snap_q.rd_index);
        2'd1:    cathode_d = hex_to_seg(snap_q.rd_data[7:4]);
        default: cathode_d = hex_to_seg(snap_q.rd_data[3:0]);
      endcase
    end else begin
      case (digit_sel)
        2'd3:    cathode_d = snap_q.full     ? SEG_F    : SEG_BLANK;
        2'd2:    cathode_d = snap_q.empty    ? SEG_E    : SEG_BLANK;
        2'd1:    cathode_d = snap_q.overflow ? SEG_LO_O : SEG_BLANK;
        default: cathode_d = SEG_BLANK;
      endcase
    end
    if (snap_q.overflow && blink_q) begin
      cathode_d[7] = 1'b0;
    end

    // Cathodes keep their pattern during blanking; the anodes alone hide it
    anode_d = 4'b1111;
    if (!blank) begin
      anode_d[digit_sel] = 1'b0;
    end
  end

  // Registered display outputs
  always_ff @(posedge CLK100 or posedge reset) begin
    if (reset) begin
      anode_q   <= 4'b1111;
      cathode_q <= 8'hFF;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign ss_anode   = anode_q;
  assign ss_cathode = cathode_q;

endmodule

// File: tb/tb_fifo_ssd_display.sv
// Bench for fifo_ssd_display with a small scan: 8 cycles per slot, 2 blank
// cycles, blink phase every 2 frames.
module tb_fifo_ssd_display;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RD;
  localparam int MAXF  = 64;

  // ---------------- clock / reset ----------------
  logic       CLK100 = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] fifo_rd_data = '0;
  logic [3:0] wr_index = '0;
  logic [3:0] rd_index = '0;
  logic       empty = 1'b0;
  logic       full = 1'b0;
  logic       overflow = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] ss_anode;
  logic [7:0] ss_cathode;

  always #5 CLK100 = ~CLK100;

  fifo_ssd_display #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .CLK100      (CLK100),
    .reset       (reset),
    .fifo_rd_data(fifo_rd_data),
    .wr_index    (wr_index),
    .rd_index    (rd_index),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .mode        (mode),
    .ss_anode    (ss_anode),
    .ss_cathode  (ss_cathode)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n = clock edges since reset release. Outputs seen after edge n describe
  // time step t = n-1. Frame f owns steps [f*FRAME, (f+1)*FRAME) and shows
  // the inputs present at edge f*FRAME (frame 0 shows all zeros).
  typedef struct packed {
    logic [7:0] d;
    logic [3:0] wr;
    logic [3:0] rd;
    logic       em;
    logic       fu;
    logic       ov;
    logic       md;
  } m_snap_t;

  int      n = 0;
  m_snap_t snaps [MAXF];

  always @(posedge CLK100 or posedge reset) begin
    if (reset) begin
      n = 0;
      snaps[0] = '0;
    end else begin
      n = n + 1;
      if ((n % FRAME) == 0 && (n / FRAME) < MAXF)
        snaps[n / FRAME] = '{fifo_rd_data, wr_index, rd_index, empty, full, overflow, mode};
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic model_at(input int t, output logic [3:0] an, output logic [7:0] ca);
    int p, d, f;
    m_snap_t s;
    p = t % RD;
    d = 3 - ((t / RD) % 4);
    f = t / FRAME;
    s = (f < MAXF) ? snaps[f] : '0;
    an = (p < BC) ? 4'b1111 : ~(4'b0001 << d);
    if (!s.md) begin
      case (d)
        3: ca = seg_of(s.wr);
        2: ca = seg_of(s.rd);
        1: ca = seg_of(s.d[7:4]);
        default: ca = seg_of(s.d[3:0]);
      endcase
    end else begin
      case (d)
        3: ca = s.fu ? 8'h8E : 8'hFF;
        2: ca = s.em ? 8'h86 : 8'hFF;
        1: ca = s.ov ? 8'hA3 : 8'hFF;
        default: ca = 8'hFF;
      endcase
    end
    if (s.ov && ((f / BF) % 2 == 1)) ca[7] = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK100) begin
    logic [3:0] ea;
    logic [7:0] ec;
    if (reset || n == 0) begin
      ea = 4'b1111;
      ec = 8'hFF;
    end else begin
      model_at(n - 1, ea, ec);
    end
    chk("cyc_anode", {28'd0, ss_anode}, {28'd0, ea});
    chk("cyc_cathode", {24'd0, ss_cathode}, {24'd0, ec});
  end

  // ---------------- driver helpers ----------------
  // Advance (on falling edges) to step frame f, digit d, slot position p
  task automatic goto(input int f, input int d, input int p);
    int tgt;
    int g;
    tgt = f * FRAME + (3 - d) * RD + p;
    g = 0;
    while ((n - 1) < tgt && g < 20000) begin
      @(negedge CLK100);
      g++;
    end
    chk("goto_step", n - 1, tgt);
  endtask

  task automatic set_inputs(input logic [7:0] d, input logic [3:0] w, input logic [3:0] r,
                            input logic em, input logic fu, input logic ov, input logic md);
    fifo_rd_data = d; wr_index = w; rd_index = r;
    empty = em; full = fu; overflow = ov; mode = md;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [3:0] exp_q[$];
    logic [3:0] seen_q[$];
    logic [3:0] an, prev;
    int first_low, run, off, multi, nf;
    logic [7:0] s5 [4];
    bit run_done;

    // Reset, release, then assert reset again in the middle of a lit slot
    repeat (3) @(negedge CLK100);
    reset = 1'b0;
    repeat (13) @(negedge CLK100);
    chk("pre_reset_lit", {28'd0, ss_anode}, 32'hB);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_anode", {28'd0, ss_anode}, 32'hF);
    chk("async_rst_cathode", {24'd0, ss_cathode}, 32'hFF);
    repeat (2) @(negedge CLK100);
    reset = 1'b0;

    // Free-run 64 cycles: startup latency, slot timing and scan order
    exp_q = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0111, 4'b1011, 4'b1101, 4'b1110};
    first_low = 0; run = 0; off = 0; multi = 0; run_done = 0; prev = 4'b1111;
    for (int i = 1; i <= 64; i++) begin
      @(negedge CLK100);
      an = ss_anode;
      if (an == 4'b1111) off++;
      else if ($countones(~an) != 1) multi++;
      if (an != 4'b1111 && prev == 4'b1111) seen_q.push_back(an);
      if (first_low == 0 && an != 4'b1111) first_low = i;
      if (first_low != 0 && !run_done) begin
        if (an != 4'b1111) run++;
        else run_done = 1;
      end
      prev = an;
    end
    chk("first_lit_cycle", first_low, 3);
    chk("first_lit_len", run, 6);
    chk("blank_cycles_64", off, 16);
    chk("multi_anode", multi, 0);
    chk("slot_count", seen_q.size(), exp_q.size());
    while (exp_q.size() > 0 && seen_q.size() > 0)
      chk("scan_order", {28'd0, seen_q.pop_front()}, {28'd0, exp_q.pop_front()});

    // Data view, then change rd_data while digit 2 is on screen
    set_inputs(8'h3A, 4'h5, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    nf = n / FRAME + 1;
    goto(nf, 3, 4); chk("data_d3", {24'd0, ss_cathode}, 32'h92);
    goto(nf, 2, 4); chk("data_d2", {24'd0, ss_cathode}, 32'hC6);
    fifo_rd_data = 8'h7F;
    goto(nf, 1, 4); chk("coh_d1_old", {24'd0, ss_cathode}, 32'hB0);
    goto(nf, 0, 4); chk("coh_d0_old", {24'd0, ss_cathode}, 32'h88);
    goto(nf + 1, 1, 4); chk("coh_d1_new", {24'd0, ss_cathode}, 32'hF8);
    goto(nf + 1, 0, 4); chk("coh_d0_new", {24'd0, ss_cathode}, 32'h8E);

    // Status view with overflow: segments fixed, DP follows the blink phase
    set_inputs(8'h7F, 4'h5, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1);
    s5 = '{8'h8E, 8'hFF, 8'hA3, 8'hFF};
    nf = n / FRAME + 1;
    for (int k = 0; k < 4; k++) begin
      for (int d = 3; d >= 0; d--) begin
        goto(nf + k, d, 4);
        chk("status_seg", {25'd0, ss_cathode[6:0]}, {25'd0, s5[3 - d][6:0]});
        chk("status_dp", {31'd0, ss_cathode[7]}, (((nf + k) / 2) % 2 == 1) ? 32'd0 : 32'd1);
      end
    end

    // Only empty set: E on digit 2, DP steady off
    set_inputs(8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    nf = n / FRAME + 1;
    goto(nf, 3, 4); chk("empty_d3", {24'd0, ss_cathode}, 32'hFF);
    goto(nf, 2, 4); chk("empty_d2", {24'd0, ss_cathode}, 32'h86);
    goto(nf, 1, 4); chk("empty_d1", {24'd0, ss_cathode}, 32'hFF);
    goto(nf, 0, 4); chk("empty_d0", {24'd0, ss_cathode}, 32'hFF);
    goto(nf + 2, 2, 4); chk("empty_d2_later", {24'd0, ss_cathode}, 32'h86);

    @(negedge CLK100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
